// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit serializer between NUM_REQ byte producers.
// Optional stalled-owner grant revocation is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int DATA_BITS    = 8,
  parameter int NUM_REQ      = 4,
  parameter int BURST_MAX    = 4,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         ser_start,
  output logic [DATA_BITS-1:0]         ser_data,
  input  logic                         ser_busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         active,
  output logic                         timeout_err
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_LOAD, S_START, S_WAIT_HI, S_WAIT_LO
  } state_t;

  state_t               state;
  logic [IDW-1:0]       rr_ptr;
  logic [7:0]           burst_cnt;
  logic                 last_flag;

  logic                 sel_valid;
  logic                 sel_last;
  logic [DATA_BITS-1:0] sel_data;
  logic [IDW-1:0]       pick;
  logic [IDW-1:0]       idx;
  logic [IDW-1:0]       rr_next;
  logic                 accept;
  logic                 release_now;
  logic                 tmo_hit;

  // Owner's request lines
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Downward scan so the lowest offset from rr_ptr wins
  always_comb begin
    pick = rr_ptr;
    idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[idx]) pick = idx;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_LOAD && !ser_busy) req_ready[grant_id] = 1'b1;
  end

  assign rr_next     = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign accept      = (state == S_LOAD) && !ser_busy && sel_valid;
  assign release_now = last_flag || (burst_cnt == 8'(BURST_MAX));

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == S_LOAD) && !sel_valid && (tmo_cnt == TW'(IDLE_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_hit;
      if (state != S_LOAD || accept || tmo_hit) tmo_cnt <= '0;
      else if (!sel_valid)                      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo  = (IDLE_TIMEOUT != 0);
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      ser_start <= 1'b0;
      ser_data  <= '0;
      grant_id  <= '0;
      active    <= 1'b0;
      burst_cnt <= '0;
      last_flag <= 1'b0;
    end else begin
      ser_start <= 1'b0;
      case (state)
        S_IDLE: if (|req_valid) state <= S_ARB;
        S_ARB: begin
          if (|req_valid) begin
            grant_id  <= pick;
            active    <= 1'b1;
            burst_cnt <= '0;
            state     <= S_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (accept) begin
            ser_data  <= sel_data;
            last_flag <= sel_last;
            if (burst_cnt != 8'hFF) burst_cnt <= burst_cnt + 8'd1;
            ser_start <= 1'b1;
            state     <= S_START;
          end else if (tmo_hit) begin
            rr_ptr <= rr_next;
            active <= 1'b0;
            state  <= S_IDLE;
          end
        end
        S_START:   state <= S_WAIT_HI;
        S_WAIT_HI: if (ser_busy) state <= S_WAIT_LO;
        S_WAIT_LO: begin
          if (!ser_busy) begin
            if (release_now) begin
              rr_ptr <= rr_next;
              active <= 1'b0;
              state  <= S_IDLE;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
